// File: rtl/sid_env_vca_pkg.sv
// Shared definitions for the SID voice amplitude stage: state encoding and default widths.
package sid_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } vca_state_e;

    localparam int SID_WAVE_W = 8;
    localparam int SID_ENV_W  = 4;

endpackage

// File: rtl/sid_env_vca_if.sv
// Sample/envelope input and scaled-sample output bundle between the ADSR voice path and the mixer.
interface sid_env_vca_if #(
    parameter int WAVE_W = 8,
    parameter int ENV_W  = 4
);
    logic              sample_stb;
    logic [WAVE_W-1:0] wave_in;
    logic [ENV_W-1:0]  env_in;
    logic              overrun_clr;
    logic              busy;
    logic              out_valid;
    logic [WAVE_W-1:0] out_sample;
    logic              overrun;

    modport master (
        output sample_stb, wave_in, env_in, overrun_clr,
        input  busy, out_valid, out_sample, overrun
    );

    modport slave (
        input  sample_stb, wave_in, env_in, overrun_clr,
        output busy, out_valid, out_sample, overrun
    );
endinterface

// File: rtl/sid_env_vca_serial_mul.sv
// Serial shift-add multiplier: consumes one envelope bit per step, LSB first.
module sid_serial_mul
    import sid_pkg::*;
#(
    parameter int WAVE_W = SID_WAVE_W,
    parameter int ENV_W  = SID_ENV_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              step,
    input  logic [WAVE_W-1:0] wave,
    input  logic [ENV_W-1:0]  env,
    output logic              done,
    output logic [WAVE_W-1:0] prod
);
    localparam int ACC_W = WAVE_W + ENV_W;
    localparam int CNT_W = $clog2(ENV_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ENV_W - 1);

    logic [ACC_W-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_sum;
    logic [ENV_W-1:0] env_q, env_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Sum including the current step, so the last step's result is usable in the same cycle.
    assign acc_sum = env_q[0] ? (acc_q + mcand_q) : acc_q;
    assign done    = step && (cnt_q == LAST);
    assign prod    = acc_sum[ACC_W-1:ENV_W];

    always_comb begin
        acc_d   = acc_q;
        mcand_d = mcand_q;
        env_d   = env_q;
        cnt_d   = cnt_q;
        if (start) begin
            acc_d   = '0;
            mcand_d = {{ENV_W{1'b0}}, wave};
            env_d   = env;
            cnt_d   = '0;
        end else if (step) begin
            acc_d   = acc_sum;
            mcand_d = mcand_q << 1;
            env_d   = env_q >> 1;
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            mcand_q <= '0;
            env_q   <= '0;
            cnt_q   <= '0;
        end else begin
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            env_q   <= env_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: rtl/sid_env_vca.sv
// Voice amplitude stage: scales a waveform sample by the envelope value and strobes the result out.
module sid_env_vca
    import sid_pkg::*;
#(
    parameter int WAVE_W = SID_WAVE_W,
    parameter int ENV_W  = SID_ENV_W
) (
    input  logic          clk,
    input  logic          rst,
    sid_env_vca_if.slave  bus
);
    vca_state_e        state_q, state_d;
    logic              start, step, done;
    logic [WAVE_W-1:0] prod;
    logic [WAVE_W-1:0] out_sample_q, out_sample_d;
    logic              out_valid_q, out_valid_d;
    logic              overrun_q, overrun_d;

    assign step = (state_q == MUL);

    sid_serial_mul #(
        .WAVE_W (WAVE_W),
        .ENV_W  (ENV_W)
    ) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .step  (step),
        .wave  (bus.wave_in),
        .env   (bus.env_in),
        .done  (done),
        .prod  (prod)
    );

    always_comb begin
        state_d      = state_q;
        start        = 1'b0;
        out_valid_d  = 1'b0;
        out_sample_d = out_sample_q;
        overrun_d    = overrun_q;
        if (bus.overrun_clr) overrun_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.sample_stb) begin
                    start   = 1'b1;
                    state_d = MUL;
                end
            end
            MUL: begin
                // A strobe during a multiply is dropped; setting the flag overrides a clear.
                if (bus.sample_stb) overrun_d = 1'b1;
                if (done) begin
                    out_valid_d  = 1'b1;
                    out_sample_d = prod;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            out_valid_q  <= 1'b0;
            out_sample_q <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_sample_q <= out_sample_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.busy       = (state_q == MUL);
    assign bus.out_valid  = out_valid_q;
    assign bus.out_sample = out_sample_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: doc/sid_env_vca.md
Name: sid_env_vca

Overview:
- Voice amplitude stage that sits directly downstream of the ADSR envelope generator.
- Scales each unsigned waveform sample by the generator's 4-bit envelope value and delivers a registered, strobed output sample to the voice mixer.
- Uses a serial shift-add multiplier: one envelope bit per clock, so no hard multiplier is needed.
- Flags any sample strobe that arrives while a multiply is still in progress.

Parameters:
- WAVE_W, 8, width of the unsigned waveform sample and of the output sample.
- ENV_W, 4, width of the envelope value; also the number of multiply cycles.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- sample_stb  in  1  one-cycle strobe; wave_in and env_in are valid in this cycle.
- wave_in  in  WAVE_W  unsigned waveform sample.
- env_in  in  ENV_W  envelope value (adsr_value from the ADSR generator).
- overrun_clr  in  1  clears the overrun flag.
- busy  out  1  high while a multiply is in progress.
- out_valid  out  1  one-cycle strobe; out_sample has just been updated.
- out_sample  out  WAVE_W  scaled sample, held between strobes.
- overrun  out  1  sticky; a strobe arrived while busy.

Behaviour:
- Reset values:
  - state = IDLE; busy = 0; out_valid = 0; out_sample = 0; overrun = 0.
  - Internal accumulator, multiplicand, envelope shift register and step counter all = 0.
- Reset mid-multiply: the operation is aborted, the result is discarded and no out_valid is produced.
- States:
  - IDLE: if sample_stb is high, latch the operands into the working registers, clear the accumulator and step count, and go to MUL. Otherwise stay.
  - MUL: one step per clock.
    - If the envelope register LSB is 1, add the multiplicand to the accumulator.
    - Shift the multiplicand left by 1 and the envelope register right by 1; increment the step count.
    - On step ENV_W-1 (the last step): write out_sample = final accumulator bits [WAVE_W+ENV_W-1 : ENV_W], assert out_valid, return to IDLE.
- Operand latching:
  - wave_in and env_in are latched only at acceptance.
  - Changes to either during MUL have no effect on the current product.
- Arithmetic:
  - Accumulator width is WAVE_W+ENV_W; the sum cannot overflow.
  - out_sample = (wave × env) >> ENV_W, truncated (no rounding).
  - Full scale: 255 × 15 → 239.
- Latency (ENV_W = 4):
  - Strobe sampled at edge E0.
  - MUL steps at edges E1 to E4; out_sample and out_valid update at E4.
  - out_valid is high for exactly the cycle after E4.
  - busy = (state == MUL): high from after E0 until after E4.
  - Minimum strobe spacing is ENV_W+1 cycles (the next accept is possible at E5).
- A strobe in the same cycle that out_valid is high is accepted normally, because state is IDLE.
- out_valid is never high for two consecutive cycles.
- Overrun:
  - sample_stb while in MUL is ignored: operands are not latched and the multiply in progress is unaffected.
  - Such a strobe sets overrun on the next edge.
  - overrun_clr clears overrun. If a set and a clear occur in the same cycle, the set wins.
- env_in = 0 still takes the full ENV_W cycles and yields out_sample = 0 with an out_valid strobe. There is no fast path, so latency is constant.

Decomposition:
- Shared package sid_pkg:
  - VCA state encodings (IDLE = 1'b0, MUL = 1'b1).
  - Default widths: SID_WAVE_W = 8, SID_ENV_W = 4.
- One sub-module is natural: sid_serial_mul.
  - Contains the start/done shift-add datapath: accumulator, multiplicand, envelope shift register and step counter.
  - sid_env_vca keeps the state machine, overrun logic and output registers.

Test Plan:
- wave_in = 255, env_in = 15, single strobe → out_valid exactly 5 cycles after the strobe cycle; out_sample = 239 (0xEF); busy high for 4 cycles.
- wave_in = 128, env_in = 8 → out_sample = 64. wave_in = 128, env_in = 1 → out_sample = 8. wave_in = 200, env_in = 0 → out_sample = 0, still with an out_valid strobe at the same latency.
- Strobe with wave_in = 100, env_in = 10, then change env_in to 15 during MUL → out_sample = 62 (1000 >> 4). Then a second strobe at cycle +2 → overrun = 1 and the first result is unaffected. overrun_clr → overrun = 0. Simultaneous set and clear → overrun stays 1.
- Back-to-back strobes exactly 5 cycles apart, for 20 random samples → every sample accepted, overrun stays 0, each out_sample equals (wave × env) >> 4.
- Assert rst for one cycle during the third MUL step → no out_valid follows. After reset: out_sample = 0, busy = 0, overrun = 0. A new strobe then completes normally.
